// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and helpers for the branch predictor slice:
//               the 2-bit saturating counter state and its direction decode.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // 2-bit saturating counter states of the predictor
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } state_t;

  // Weakly/strongly taken states both predict taken, so the MSB is the direction
  function automatic logic pred_dir(input state_t s);
    logic [1:0] v;
    v = s;
    return v[1];
  endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_pred_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bp_pred_fifo
// Description : Generic synchronous FIFO with full/empty/count outputs and a
//               synchronous clear that overrides any write or read.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_pred_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] c_ptr_one   = PTR_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_wr;
  logic w_rd;

  // Full/empty come from the registered count only, so there is no
  // combinational path from the request inputs to the ready outputs.
  assign full  = (r_count == c_depth_cnt);
  assign empty = (r_count == '0);
  assign count = r_count;

  // Write refused when full, read refused when empty; clear wins over both
  assign w_wr = wr_en & ~full  & ~clear;
  assign w_rd = rd_en & ~empty & ~clear;

  assign rd_data = r_mem[r_rd_ptr];

  // Storage array: contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : bp_pred_fifo
`default_nettype wire

// File: rtl/bp_outcome_tracker.sv
`default_nettype none
// ============================================================================
// Module      : bp_outcome_tracker
// Description : Queues predictor states between fetch and resolution, compares
//               the oldest prediction with the resolved outcome, emits a
//               registered training pulse plus mispredict flag, and keeps
//               saturating branch / misprediction counters.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_outcome_tracker
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pred_valid,
  input  logic [1:0]             pred_state,
  output logic                   pred_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   res_ready,
  input  logic                   flush,
  output logic                   upd_valid,
  output logic                   upd_taken,
  output logic                   mispredict,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       branch_count,
  output logic [CNT_W-1:0]       mispredict_count
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [1:0]       w_head;
  state_t           w_head_state;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_miss;

  logic             r_upd_valid;
  logic             r_upd_taken;
  logic             r_mispredict;
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  bp_pred_fifo #(
    .WIDTH (2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .wr_en   (pred_valid),
    .wr_data (pred_state),
    .rd_en   (res_valid),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (occupancy)
  );

  assign pred_ready = ~w_full;
  assign res_ready  = ~w_empty;

  // Must match the FIFO's own read acceptance: a flush suppresses the pop and
  // a resolve while empty is silently ignored.
  assign w_pop        = res_valid & ~w_empty & ~flush;
  assign w_head_state = state_t'(w_head);
  assign w_miss       = (res_taken != pred_dir(w_head_state));

  assign upd_valid        = r_upd_valid;
  assign upd_taken        = r_upd_taken;
  assign mispredict       = r_mispredict;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

  // One-cycle training pulse; taken/mispredict are forced low without a pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_upd_valid  <= 1'b0;
      r_upd_taken  <= 1'b0;
      r_mispredict <= 1'b0;
    end else begin
      r_upd_valid  <= w_pop;
      r_upd_taken  <= w_pop & res_taken;
      r_mispredict <= w_pop & w_miss;
    end
  end

  // Saturating statistics counters; deliberately untouched by flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_pop) begin
      if (r_branch_count != c_cnt_max) begin
        r_branch_count <= r_branch_count + c_cnt_one;
      end
      if (w_miss && (r_mispredict_count != c_cnt_max)) begin
        r_mispredict_count <= r_mispredict_count + c_cnt_one;
      end
    end
  end

endmodule : bp_outcome_tracker
`default_nettype wire

// File: tb/tb_bp_outcome_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_outcome_tracker
// Description : Self-checking bench for bp_outcome_tracker with a reference
//               queue model and a scoreboard of expected training pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_outcome_tracker;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;
  localparam int OCC_W   = $clog2(DEPTH) + 1;
  localparam int S_DEPTH = 4;
  localparam int S_CNT_W = 2;

  logic clk = 1'b0;
  logic reset;

  // main instance
  logic             pred_valid, res_valid, res_taken, flush;
  logic [1:0]       pred_state;
  logic             pred_ready, res_ready, upd_valid, upd_taken, mispredict;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  // narrow-counter instance used for saturation
  logic               s_pred_valid, s_res_valid, s_res_taken, s_flush;
  logic [1:0]         s_pred_state;
  logic               s_pred_ready, s_res_ready, s_upd_valid, s_upd_taken, s_mispredict;
  logic [2:0]         s_occupancy;
  logic [S_CNT_W-1:0] s_branch_count, s_mispredict_count;

  int checks   = 0;
  int failures = 0;

  // reference model
  logic [1:0] m_q[$];
  logic [1:0] exp_q[$];      // {upd_taken, mispredict} per accepted pop
  int         m_branch = 0;
  int         m_miss   = 0;

  always #5 clk = ~clk;

  bp_outcome_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .pred_state       (pred_state),
    .pred_ready       (pred_ready),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .res_ready        (res_ready),
    .flush            (flush),
    .upd_valid        (upd_valid),
    .upd_taken        (upd_taken),
    .mispredict       (mispredict),
    .occupancy        (occupancy),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  bp_outcome_tracker #(.DEPTH(S_DEPTH), .CNT_W(S_CNT_W)) u_sat (
    .clk              (clk),
    .reset            (reset),
    .pred_valid       (s_pred_valid),
    .pred_state       (s_pred_state),
    .pred_ready       (s_pred_ready),
    .res_valid        (s_res_valid),
    .res_taken        (s_res_taken),
    .res_ready        (s_res_ready),
    .flush            (s_flush),
    .upd_valid        (s_upd_valid),
    .upd_taken        (s_upd_taken),
    .mispredict       (s_mispredict),
    .occupancy        (s_occupancy),
    .branch_count     (s_branch_count),
    .mispredict_count (s_mispredict_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus on the main instance, then compare against the model
  task automatic step(input logic pv, input logic [1:0] ps, input logic rv,
                      input logic rt, input logic fl);
    logic       pop_ok, push_ok, miss;
    logic [1:0] head, e;
    pred_valid = pv; pred_state = ps; res_valid = rv; res_taken = rt; flush = fl;
    pop_ok  = !fl && rv && (m_q.size() > 0);
    push_ok = !fl && pv && (m_q.size() < DEPTH);
    if (pop_ok) begin
      head = m_q.pop_front();
      miss = (rt != head[1]);
      exp_q.push_back({rt, miss});
      if (m_branch < (1 << CNT_W) - 1) m_branch++;
      if (miss && m_miss < (1 << CNT_W) - 1) m_miss++;
    end
    if (push_ok) m_q.push_back(ps);
    if (fl) m_q.delete();
    @(posedge clk);
    #1;
    check_eq("upd_valid", {31'b0, upd_valid}, {31'b0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("upd_taken", {31'b0, upd_taken}, {31'b0, e[1]});
      check_eq("mispredict", {31'b0, mispredict}, {31'b0, e[0]});
    end else begin
      check_eq("upd_taken_idle", {31'b0, upd_taken}, 32'd0);
      check_eq("mispredict_idle", {31'b0, mispredict}, 32'd0);
    end
    check_eq("occupancy", {28'b0, occupancy}, m_q.size());
    check_eq("pred_ready", {31'b0, pred_ready}, {31'b0, m_q.size() < DEPTH});
    check_eq("res_ready", {31'b0, res_ready}, {31'b0, m_q.size() > 0});
    check_eq("branch_count", {16'b0, branch_count}, m_branch);
    check_eq("mispredict_count", {16'b0, mispredict_count}, m_miss);
    pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic s_step(input logic pv, input logic [1:0] ps, input logic rv, input logic rt);
    s_pred_valid = pv; s_pred_state = ps; s_res_valid = rv; s_res_taken = rt;
    @(posedge clk);
    #1;
    s_pred_valid = 1'b0; s_res_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_occupancy"}, {28'b0, occupancy}, 32'd0);
    check_eq({tag, "_pred_ready"}, {31'b0, pred_ready}, 32'd1);
    check_eq({tag, "_res_ready"}, {31'b0, res_ready}, 32'd0);
    check_eq({tag, "_upd_valid"}, {31'b0, upd_valid}, 32'd0);
    check_eq({tag, "_upd_taken"}, {31'b0, upd_taken}, 32'd0);
    check_eq({tag, "_mispredict"}, {31'b0, mispredict}, 32'd0);
    check_eq({tag, "_branch_count"}, {16'b0, branch_count}, 32'd0);
    check_eq({tag, "_mispredict_count"}, {16'b0, mispredict_count}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    pred_valid = 1'b0; pred_state = 2'd0; res_valid = 1'b0; res_taken = 1'b0; flush = 1'b0;
    s_pred_valid = 1'b0; s_pred_state = 2'd0; s_res_valid = 1'b0; s_res_taken = 1'b0;
    s_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset");

    // Each predictor state resolved taken: only the not-taken predictions miss
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    check_eq("plan_branch_count", {16'b0, branch_count}, 32'd4);
    check_eq("plan_mispredict_count", {16'b0, mispredict_count}, 32'd2);

    // Fill to DEPTH, then simultaneous push+pop while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    check_eq("full_pred_ready", {31'b0, pred_ready}, 32'd0);
    check_eq("full_occupancy", {28'b0, occupancy}, DEPTH);
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    check_eq("full_pushpop_occupancy", {28'b0, occupancy}, DEPTH - 1);
    // Concurrent push/pop with random data, then drain
    for (int i = 0; i < 6; i++)
      step(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    while (m_q.size() > 0) step(1'b0, 2'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);

    // Empty with both valid: push only, no bypass
    step(1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    check_eq("empty_both_occupancy", {28'b0, occupancy}, 32'd1);
    check_eq("empty_both_upd_valid", {31'b0, upd_valid}, 32'd0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    // Resolve while empty is ignored
    step(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);

    // Flush with a concurrent resolve
    for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    begin
      logic [CNT_W-1:0] bc, mc;
      bc = branch_count;
      mc = mispredict_count;
      step(1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
      check_eq("flush_occupancy", {28'b0, occupancy}, 32'd0);
      check_eq("flush_upd_valid", {31'b0, upd_valid}, 32'd0);
      check_eq("flush_branch_count", {16'b0, branch_count}, {16'b0, bc});
      check_eq("flush_mispredict_count", {16'b0, mispredict_count}, {16'b0, mc});
    end

    // Saturation on a 2-bit-counter instance: reach 2, then 3 more misses
    for (int i = 0; i < 5; i++) begin
      s_step(1'b1, 2'd3, 1'b0, 1'b0);
      s_step(1'b0, 2'd0, 1'b1, 1'b0);
      check_eq("sat_mispredict_pulse", {31'b0, s_mispredict}, 32'd1);
      if (i == 1) begin
        check_eq("sat_pre_branch", {30'b0, s_branch_count}, 32'd2);
        check_eq("sat_pre_miss", {30'b0, s_mispredict_count}, 32'd2);
      end
    end
    check_eq("sat_branch", {30'b0, s_branch_count}, 32'd3);
    check_eq("sat_miss", {30'b0, s_mispredict_count}, 32'd3);

    // Reset mid-stream with 5 entries queued and a pulse in flight
    for (int i = 0; i < 6; i++) step(1'b1, 2'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    check_eq("pre_reset_occupancy", {28'b0, occupancy}, 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    m_q.delete();
    exp_q.delete();
    m_branch = 0;
    m_miss   = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the bench must always reach its summary on its own
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule : tb_bp_outcome_tracker
`default_nettype wire
